output_buffer: RTL and testbench
================================

// Module: output_buffer
// PURPOSE
//  Write-side counterpart of the input buffering path. Collects 512-bit result beats from the conv
//  datapath into a FIFO and drains them as an AXI-stream to the write master. Issues one write
//  request per burst (addr/size), waits for completion, and pulses op_done when the byte count is written.
// PARAMETERS
//  DATA_WIDTH        512         beat width in bits
//  DATA_WIDTH_BYTE   DATA_WIDTH/8 bytes per beat (64)
//  FIFO_ADDR_WIDTH   7           FIFO depth = 2**FIFO_ADDR_WIDTH (128 beats)
//  BURST_LENGTH      64          max beats per write request; must be <= FIFO depth
//  BURST_LENGTH_BYTE DATA_WIDTH_BYTE*BURST_LENGTH  bytes per full burst
// PORTS
//  clk          in  1    clock
//  rst          in  1    async reset, active-high
//  op_start     in  1    1-cycle pulse: latch addr_base/output_byte, start job
//  end_conv     in  1    abort: clear FIFO, return to IDLE
//  addr_base    in  64   job base byte address (64B aligned)
//  output_byte  in  32   job size in bytes; bits[5:0] ignored
//  push_req     in  1    datapath result beat valid
//  push_data    in  512  result beat
//  full         out 1    FIFO full; datapath must stall
//  wmst_req     out 1    1-cycle write request pulse
//  wmst_done    in  1    1-cycle completion pulse for current request
//  addr_offset  out 64   byte address of current burst
//  xfer_size    out 64   byte size of current burst
//  tdata        out 512  stream data to write master
//  tvalid       out 1    stream valid
//  tready       in  1    stream ready
//  op_done      out 1    1-cycle pulse, all bytes written
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, FIFO empty, counters 0.
//  - Push accepted when push_req & !full & busy (state != IDLE); beats pushed in IDLE dropped.
//  - total_beats = output_byte[31:6]; rem_beats counts down per completed burst.
//  - burst_beats = min(BURST_LENGTH, rem_beats); xfer_size = burst_beats*DATA_WIDTH_BYTE.
//  - addr_offset = addr_base_latched + burst_idx*BURST_LENGTH_BYTE; stable from wmst_req to wmst_done.
//  - FSM: IDLE -op_start-> (total_beats==0 ? DONE : FILL)
//    FILL: wait data_cnt >= burst_beats -> REQ
//    REQ : wmst_req=1 one cycle -> XFER
//    XFER: tvalid = !empty; pop on tvalid&tready; after burst_beats pops -> WAIT
//    WAIT: on wmst_done (or done_seen flag set during XFER/REQ) -> rem_beats==0 ? DONE : FILL
//    DONE: op_done=1 one cycle -> IDLE
//  - tdata = FIFO head (first-word-fall-through); tvalid only in XFER with beats left in burst.
//  - Push and pop same cycle at full: pop frees slot, push still blocked that cycle (full registered).
//  - end_conv any state: FIFO cleared next cycle, tvalid/wmst_req drop to 0, state IDLE, no op_done.
//    end_conv beats op_start same cycle; op_start when not IDLE ignored.
//  - wmst_done arriving before last beat pops is latched, consumed on WAIT entry.
//  - rst mid-burst: immediate return to reset values; outstanding write master state not tracked.
// CONFIGURATION
//  OUTPUT_BUFFER_STALL_CNT_EN: defined -> adds port stall_cycles out 32: counts cycles with
//  push_req & full, cleared on op_start, saturates at 2^32-1. Undefined -> port and counter absent.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE,FILL,REQ,XFER,WAIT,DONE), DATA_WIDTH_BYTE,
//  BURST_LENGTH_BYTE constants. One sub-module: obuf_fifo (sync FIFO, FWFT, CLEAR, DATA_CNT,
//  async active-high reset).
// TESTING
//  1 output_byte=8192, addr_base=0x1000, full push -> two wmst_req, addr 0x1000/0x2000, size 4096, op_done after 2nd done.
//  2 output_byte=4160 -> bursts 64 beats then 1 beat; 2nd xfer_size=64, addr 0x2000.
//  3 tready toggling 50%, push 128 beats nonstop -> full asserts at 128 held, no beat lost/reordered.
//  4 wmst_done pulsed on same cycle as last pop of burst -> FSM advances, no hang, op_done once.
//  5 end_conv mid-XFER after 10 beats -> tvalid=0 next cycle, FIFO empty, state IDLE, no op_done.
//  6 OUTPUT_BUFFER_STALL_CNT_EN, push_req held 5 cycles while full -> stall_cycles=5.

Source files
------------

// File: rtl/output_buffer_pkg.sv
// Shared constants and FSM encoding for the output buffer and its FIFO.
// Imported by output_buffer and obuf_fifo.
package output_buffer_pkg;

  localparam int DATA_WIDTH        = 512;
  localparam int DATA_WIDTH_BYTE   = DATA_WIDTH / 8;
  localparam int FIFO_ADDR_WIDTH   = 7;
  localparam int BURST_LENGTH      = 64;
  localparam int BURST_LENGTH_BYTE = DATA_WIDTH_BYTE * BURST_LENGTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_REQ,
    S_XFER,
    S_WAIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/obuf_fifo.sv
// Synchronous first-word-fall-through FIFO with a synchronous clear and an occupancy count.
// A push is refused while full, even if a pop frees a slot in the same cycle.
module obuf_fifo #(
  parameter int DW = 512,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   data_cnt
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (data_cnt == DEPTH[AW:0]);
  assign empty    = (data_cnt == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      data_cnt <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      data_cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   data_cnt <= data_cnt + 1'b1;
        2'b01:   data_cnt <= data_cnt - 1'b1;
        default: data_cnt <= data_cnt;
      endcase
    end
  end

  // Storage carries no reset; stale words are never visible because empty gates the reader.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/output_buffer.sv
// Buffers datapath result beats and drains them to the write master one burst request at a time.
// Defining OUTPUT_BUFFER_STALL_CNT_EN adds the stall_cycles counter port.
module output_buffer
  import output_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_start,
  input  logic                  end_conv,
  input  logic [63:0]           addr_base,
  input  logic [31:0]           output_byte,
  input  logic                  push_req,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  full,
  output logic                  wmst_req,
  input  logic                  wmst_done,
  output logic [63:0]           addr_offset,
  output logic [63:0]           xfer_size,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  tvalid,
  input  logic                  tready,
  output logic                  op_done
`ifdef OUTPUT_BUFFER_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int BEAT_W  = $clog2(BURST_LENGTH) + 1;
  localparam int TOTAL_W = 26;
  localparam int CNT_W   = FIFO_ADDR_WIDTH + 1;

  state_t              state;
  state_t              next_state;
  logic [63:0]         addr_base_q;
  logic [TOTAL_W-1:0]  rem_beats;
  logic [TOTAL_W-1:0]  burst_idx;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [BEAT_W-1:0]   burst_beats;
  logic [TOTAL_W-1:0]  rem_after;
  logic                done_seen;
  logic                done_now;
  logic                job_start;
  logic                pop;
  logic                last_pop;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_cnt;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                unused_low_bits;

  assign unused_low_bits = ^output_byte[5:0];

  assign job_start   = op_start && (state == S_IDLE) && !end_conv;
  assign burst_beats = (rem_beats > TOTAL_W'(BURST_LENGTH)) ? BEAT_W'(BURST_LENGTH)
                                                            : rem_beats[BEAT_W-1:0];
  assign rem_after   = rem_beats - TOTAL_W'(burst_beats);
  assign done_now    = wmst_done || done_seen;

  assign tvalid      = (state == S_XFER) && !fifo_empty;
  assign pop         = tvalid && tready;
  assign last_pop    = pop && (beat_cnt == burst_beats - BEAT_W'(1));
  assign tdata       = tvalid ? fifo_head : '0;
  assign wmst_req    = (state == S_REQ);
  assign op_done     = (state == S_DONE);
  assign addr_offset = addr_base_q + 64'(burst_idx) * 64'(BURST_LENGTH_BYTE);
  assign xfer_size   = 64'(burst_beats) * 64'(DATA_WIDTH_BYTE);

  obuf_fifo #(
    .DW (DATA_WIDTH),
    .AW (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (end_conv),
    .push      (push_req && (state != S_IDLE)),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (full),
    .empty     (fifo_empty),
    .data_cnt  (fifo_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Abort overrides every transition, including a same-cycle op_start.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (op_start) next_state = (output_byte[31:6] == '0) ? S_DONE : S_FILL;
      S_FILL: if (fifo_cnt >= CNT_W'(burst_beats)) next_state = S_REQ;
      S_REQ:  next_state = S_XFER;
      S_XFER: if (last_pop) next_state = S_WAIT;
      S_WAIT: if (done_now) next_state = (rem_after == '0) ? S_DONE : S_FILL;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (end_conv) next_state = S_IDLE;
  end

  // A completion seen before the last beat leaves is remembered until WAIT consumes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_base_q <= '0;
      rem_beats   <= '0;
      burst_idx   <= '0;
      beat_cnt    <= '0;
      done_seen   <= 1'b0;
    end else if (end_conv) begin
      rem_beats   <= '0;
      burst_idx   <= '0;
      beat_cnt    <= '0;
      done_seen   <= 1'b0;
    end else begin
      if (job_start) begin
        addr_base_q <= addr_base;
        rem_beats   <= output_byte[31:6];
        burst_idx   <= '0;
      end
      if (pop) beat_cnt <= last_pop ? '0 : beat_cnt + 1'b1;
      if (((state == S_REQ) || (state == S_XFER)) && wmst_done) done_seen <= 1'b1;
      if ((state == S_WAIT) && done_now) begin
        done_seen <= 1'b0;
        rem_beats <= rem_after;
        burst_idx <= burst_idx + 1'b1;
      end
    end
  end

`ifdef OUTPUT_BUFFER_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        stall_cycles <= '0;
    else if (job_start)                             stall_cycles <= '0;
    else if (push_req && full && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
  end
`endif

endmodule

// File: tb/tb_output_buffer.sv
// Directed scoreboard bench for output_buffer: expected beats and burst requests are queued
// when driven and checked when the DUT hands them to the write master model.
module tb_output_buffer;

  logic         clk;
  logic         rst;
  logic         op_start;
  logic         end_conv;
  logic [63:0]  addr_base;
  logic [31:0]  output_byte;
  logic         push_req;
  logic [511:0] push_data;
  logic         full;
  logic         wmst_req;
  logic         wmst_done;
  logic [63:0]  addr_offset;
  logic [63:0]  xfer_size;
  logic [511:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         op_done;
`ifdef OUTPUT_BUFFER_STALL_CNT_EN
  logic [31:0]  stall_cycles;
`endif

  output_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .op_start    (op_start),
    .end_conv    (end_conv),
    .addr_base   (addr_base),
    .output_byte (output_byte),
    .push_req    (push_req),
    .push_data   (push_data),
    .full        (full),
    .wmst_req    (wmst_req),
    .wmst_done   (wmst_done),
    .addr_offset (addr_offset),
    .xfer_size   (xfer_size),
    .tdata       (tdata),
    .tvalid      (tvalid),
    .tready      (tready),
    .op_done     (op_done)
`ifdef OUTPUT_BUFFER_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks_total  = 0;
  int checks_passed = 0;

  logic [511:0] exp_data_q[$];
  logic [63:0]  exp_addr_q[$];
  logic [63:0]  exp_size_q[$];

  int   op_done_cnt = 0;
  int   hs_count    = 0;
  int   flush_gen   = 0;
  logic tready_level = 1'b1;
  logic tready_rand  = 1'b0;
  logic done_early   = 1'b0;

  task automatic check_output(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Write master and stream sink model: checks requests and beats, answers with wmst_done.
  initial begin
    int   seen_gen;
    int   resp_beats;
    int   resp_cnt;
    int   resp_delay;
    logic resp_active;
    logic [63:0] cur_addr;
    logic [63:0] cur_size;
    seen_gen    = 0;
    resp_beats  = 0;
    resp_cnt    = 0;
    resp_delay  = 0;
    resp_active = 1'b0;
    cur_addr    = '0;
    cur_size    = '0;
    tready      = 1'b0;
    wmst_done   = 1'b0;
    forever begin
      @(negedge clk);
      wmst_done = 1'b0;
      if (flush_gen != seen_gen) begin
        seen_gen = flush_gen;
        exp_data_q.delete();
        exp_addr_q.delete();
        exp_size_q.delete();
        resp_active = 1'b0;
        resp_delay  = 0;
      end
      tready = tready_rand ? 1'($urandom_range(0, 1)) : tready_level;
      if (op_done) op_done_cnt++;
      if (wmst_req) begin
        check_output("req_expected", 512'(exp_addr_q.size() > 0), 512'(1));
        if (exp_addr_q.size() > 0) begin
          cur_addr = exp_addr_q.pop_front();
          cur_size = exp_size_q.pop_front();
          check_output("req_addr", 512'(addr_offset), 512'(cur_addr));
          check_output("req_size", 512'(xfer_size), 512'(cur_size));
          resp_active = 1'b1;
          resp_beats  = int'(cur_size / 64);
          resp_cnt    = 0;
          resp_delay  = 0;
        end
      end
      if (resp_delay > 0) begin
        resp_delay--;
        if (resp_delay == 0) begin
          wmst_done = 1'b1;
          check_output("addr_stable_at_done", 512'(addr_offset), 512'(cur_addr));
          resp_active = 1'b0;
        end
      end
      if (tvalid && tready) begin
        hs_count++;
        check_output("beat_expected", 512'(exp_data_q.size() > 0), 512'(1));
        if (exp_data_q.size() > 0) check_output("tdata", tdata, exp_data_q.pop_front());
        if (resp_active) begin
          resp_cnt++;
          if (resp_cnt == resp_beats) begin
            if (done_early) begin
              wmst_done = 1'b1;
              check_output("addr_stable_at_done", 512'(addr_offset), 512'(cur_addr));
              resp_active = 1'b0;
            end else begin
              resp_delay = 2;
            end
          end
        end
      end
    end
  end

  task automatic start_job(input logic [63:0] base, input logic [31:0] bytes);
    int rem;
    int idx;
    int b;
    rem = int'(bytes[31:6]);
    idx = 0;
    while (rem > 0) begin
      b = (rem > 64) ? 64 : rem;
      exp_addr_q.push_back(base + 64'(idx) * 64'd4096);
      exp_size_q.push_back(64'(b) * 64'd64);
      rem -= b;
      idx++;
    end
    addr_base   = base;
    output_byte = bytes;
    op_start    = 1'b1;
    @(negedge clk);
    op_start    = 1'b0;
  endtask

  task automatic apply_stimulus(input int count);
    int sent;
    int cycles;
    logic [511:0] d;
    sent   = 0;
    cycles = 0;
    while (sent < count && cycles < 2000) begin
      for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom();
      push_req  = 1'b1;
      push_data = d;
      if (!full) begin
        exp_data_q.push_back(d);
        sent++;
      end
      @(negedge clk);
      cycles++;
    end
    push_req = 1'b0;
    check_output("push_budget", 512'(sent), 512'(count));
  endtask

  task automatic push_unqueued(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      push_req  = 1'b1;
      push_data = {16{32'hdead_beef}};
      @(negedge clk);
    end
    push_req = 1'b0;
  endtask

  task automatic wait_op_done(input string tag, input int target);
    int n;
    n = 0;
    while (op_done_cnt < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "_op_done_seen"}, 512'(op_done_cnt), 512'(target));
    repeat (8) @(negedge clk);
    check_output({tag, "_op_done_once"}, 512'(op_done_cnt), 512'(target));
    check_output({tag, "_data_drained"}, 512'(exp_data_q.size()), 512'(0));
    check_output({tag, "_reqs_drained"}, 512'(exp_addr_q.size()), 512'(0));
  endtask

  initial begin
    int base;
    int n;
    int done_exp;
    rst         = 1'b1;
    op_start    = 1'b0;
    end_conv    = 1'b0;
    addr_base   = '0;
    output_byte = '0;
    push_req    = 1'b0;
    push_data   = '0;
    done_exp    = 0;
    repeat (3) @(negedge clk);

    check_output("rst_full", 512'(full), 512'(0));
    check_output("rst_wmst_req", 512'(wmst_req), 512'(0));
    check_output("rst_tvalid", 512'(tvalid), 512'(0));
    check_output("rst_op_done", 512'(op_done), 512'(0));
    check_output("rst_addr_offset", 512'(addr_offset), 512'(0));
    check_output("rst_xfer_size", 512'(xfer_size), 512'(0));
    check_output("rst_tdata", tdata, 512'(0));
`ifdef OUTPUT_BUFFER_STALL_CNT_EN
    check_output("rst_stall_cycles", 512'(stall_cycles), 512'(0));
`endif
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] two full bursts at 0x1000");
    start_job(64'h1000, 32'd8192);
    apply_stimulus(128);
    done_exp++;
    wait_op_done("t1", done_exp);

    $display("[TB] 65-beat job (low size bits set) ends with a one-beat burst");
    start_job(64'h1000, 32'd4160 + 32'd7);
    apply_stimulus(65);
    done_exp++;
    wait_op_done("t2", done_exp);

    $display("[TB] fill to full with stream stalled, then drain with random tready");
    tready_level = 1'b0;
    @(negedge clk);
    start_job(64'h4_0000, 32'd8192);
    apply_stimulus(128);
    check_output("t3_full_at_128", 512'(full), 512'(1));
    push_unqueued(5);
    check_output("t3_full_held", 512'(full), 512'(1));
`ifdef OUTPUT_BUFFER_STALL_CNT_EN
    check_output("t6_stall_cycles", 512'(stall_cycles), 512'(5));
`endif
    tready_rand  = 1'b1;
    tready_level = 1'b1;
    done_exp++;
    wait_op_done("t3", done_exp);
    tready_rand = 1'b0;

    $display("[TB] completion on the same cycle as the last pop");
    done_early = 1'b1;
    start_job(64'h8000, 32'd4096);
    apply_stimulus(64);
    done_exp++;
    wait_op_done("t4", done_exp);
    done_early = 1'b0;

    $display("[TB] abort in the middle of a stream transfer");
    start_job(64'h0, 32'd8192);
    apply_stimulus(64);
    base = hs_count;
    n    = 0;
    while ((hs_count - base) < 10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_output("t5_beats_before_abort", 512'((hs_count - base) >= 10), 512'(1));
    end_conv = 1'b1;
    @(negedge clk);
    end_conv = 1'b0;
    check_output("t5_tvalid_dropped", 512'(tvalid), 512'(0));
    check_output("t5_wmst_req_low", 512'(wmst_req), 512'(0));
    check_output("t5_full_low", 512'(full), 512'(0));
    flush_gen++;
    repeat (20) @(negedge clk);
    check_output("t5_no_op_done", 512'(op_done_cnt), 512'(done_exp));
    check_output("t5_tvalid_idle", 512'(tvalid), 512'(0));
    push_unqueued(3);
    start_job(64'h200, 32'd64);
    apply_stimulus(1);
    done_exp++;
    wait_op_done("t5_next_job", done_exp);

    $display("[TB] job smaller than one beat finishes without a request");
    start_job(64'h3000, 32'd63);
    done_exp++;
    wait_op_done("t7", done_exp);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
